credit_start_sequencer: RTL and testbench

//  Game-level controller fed by joystick_controller's debounced coin/p1_start/p2_start/fire levels.

---
 rtl/credit_start_sequencer.sv | 169 ++++++++++++++++
 tb/tb_credit_start_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_start_sequencer.sv
// Game-level controller: coin credits with lockout, ATTRACT/READY/PLAY sequencing,
// 2P turn tracking and rate-limited autofire, all outputs registered.
module credit_start_sequencer #(
    parameter int unsigned MAX_CREDITS     = 9,
    parameter int unsigned CREDIT_W        = 4,
    parameter int unsigned COIN_LOCKOUT    = 64,
    parameter int unsigned AUTOFIRE_PERIOD = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                coin_i,
    input  logic                p1_start_i,
    input  logic                p2_start_i,
    input  logic                fire_i,
    input  logic                turn_end_i,
    input  logic                game_over_i,
    output logic [CREDIT_W-1:0] credits_o,
    output logic [1:0]          state_o,
    output logic                two_player_o,
    output logic                active_player_o,
    output logic                start_pulse_o,
    output logic                fire_pulse_o,
    output logic                coin_locked_o
);

    localparam int unsigned LOCK_W = $clog2(COIN_LOCKOUT + 1);
    localparam int unsigned AF_W   = $clog2(AUTOFIRE_PERIOD + 1);

    localparam logic [1:0] ST_ATTRACT = 2'b00;
    localparam logic [1:0] ST_READY   = 2'b01;
    localparam logic [1:0] ST_PLAY    = 2'b10;

    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDITS);

    logic                coin_q, p1_q, p2_q, fire_q;
    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic                two_player_q, two_player_d;
    logic                active_q, active_d;
    logic                start_pulse_q, start_pulse_d;
    logic                fire_pulse_q, fire_pulse_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                coin_locked_q, coin_locked_d;
    logic [AF_W-1:0]     af_cnt_q, af_cnt_d;

    logic                coin_rise, p1_rise, p2_rise, fire_rise;
    logic                coin_add, start1, start2;
    logic [CREDIT_W-1:0] credits_sat;

    assign coin_rise = coin_i & ~coin_q;
    assign p1_rise   = p1_start_i & ~p1_q;
    assign p2_rise   = p2_start_i & ~p2_q;
    assign fire_rise = fire_i & ~fire_q;

    // Coin credit after saturation; start cost is judged on the pre-coin count
    assign coin_add    = coin_rise & ~coin_locked_q;
    assign credits_sat = (coin_add && (credits_q < MAX_C)) ? credits_q + CREDIT_W'(1) : credits_q;
    assign start1      = p1_rise && (credits_q >= CREDIT_W'(1));
    assign start2      = p2_rise && (credits_q >= CREDIT_W'(2));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            coin_q        <= 1'b0;
            p1_q          <= 1'b0;
            p2_q          <= 1'b0;
            fire_q        <= 1'b0;
            state_q       <= ST_ATTRACT;
            credits_q     <= '0;
            two_player_q  <= 1'b0;
            active_q      <= 1'b0;
            start_pulse_q <= 1'b0;
            fire_pulse_q  <= 1'b0;
            lock_cnt_q    <= '0;
            coin_locked_q <= 1'b0;
            af_cnt_q      <= '0;
        end else begin
            coin_q        <= coin_i;
            p1_q          <= p1_start_i;
            p2_q          <= p2_start_i;
            fire_q        <= fire_i;
            state_q       <= state_d;
            credits_q     <= credits_d;
            two_player_q  <= two_player_d;
            active_q      <= active_d;
            start_pulse_q <= start_pulse_d;
            fire_pulse_q  <= fire_pulse_d;
            lock_cnt_q    <= lock_cnt_d;
            coin_locked_q <= coin_locked_d;
            af_cnt_q      <= af_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ATTRACT: begin
                if (credits_sat != '0) state_d = ST_READY;
            end
            ST_READY: begin
                if (start1 || start2) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (game_over_i) state_d = (credits_sat != '0) ? ST_READY : ST_ATTRACT;
            end
            default: state_d = ST_ATTRACT;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        credits_d     = credits_sat;
        two_player_d  = two_player_q;
        active_d      = active_q;
        start_pulse_d = 1'b0;
        fire_pulse_d  = 1'b0;
        af_cnt_d      = '0;
        lock_cnt_d    = lock_cnt_q;

        if (coin_add)                lock_cnt_d = LOCK_W'(COIN_LOCKOUT - 1);
        else if (lock_cnt_q != '0)   lock_cnt_d = lock_cnt_q - LOCK_W'(1);
        coin_locked_d = (lock_cnt_d != '0);

        case (state_q)
            ST_READY: begin
                if (start2) begin
                    credits_d     = credits_sat - CREDIT_W'(2);
                    two_player_d  = 1'b1;
                    active_d      = 1'b0;
                    start_pulse_d = 1'b1;
                end else if (start1) begin
                    credits_d     = credits_sat - CREDIT_W'(1);
                    two_player_d  = 1'b0;
                    active_d      = 1'b0;
                    start_pulse_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (game_over_i)                    active_d = 1'b0;
                else if (turn_end_i && two_player_q) active_d = ~active_q;
            end
            default: ;
        endcase

        // Autofire only while staying in PLAY, so a leaving game drops the pulse at once
        if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
            if (fire_rise) begin
                fire_pulse_d = 1'b1;
                af_cnt_d     = AF_W'(AUTOFIRE_PERIOD - 1);
            end else if (fire_i) begin
                if (af_cnt_q == '0) begin
                    fire_pulse_d = 1'b1;
                    af_cnt_d     = AF_W'(AUTOFIRE_PERIOD - 1);
                end else begin
                    af_cnt_d = af_cnt_q - AF_W'(1);
                end
            end
        end
    end

    assign credits_o       = credits_q;
    assign state_o         = state_q;
    assign two_player_o    = two_player_q;
    assign active_player_o = active_q;
    assign start_pulse_o   = start_pulse_q;
    assign fire_pulse_o    = fire_pulse_q;
    assign coin_locked_o   = coin_locked_q;

endmodule

// File: tb/tb_credit_start_sequencer.sv
// Directed bench for credit_start_sequencer; pulse timing is checked against a
// scoreboard of expected pulse cycles filled as stimulus is driven.
module tb_credit_start_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       coin_i, p1_start_i, p2_start_i, fire_i, turn_end_i, game_over_i;
    logic [3:0] credits_o;
    logic [1:0] state_o;
    logic       two_player_o, active_player_o, start_pulse_o, fire_pulse_o, coin_locked_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_fire_q[$];
    int exp_start_q[$];
    int c0;

    credit_start_sequencer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .coin_i         (coin_i),
        .p1_start_i     (p1_start_i),
        .p2_start_i     (p2_start_i),
        .fire_i         (fire_i),
        .turn_end_i     (turn_end_i),
        .game_over_i    (game_over_i),
        .credits_o      (credits_o),
        .state_o        (state_o),
        .two_player_o   (two_player_o),
        .active_player_o(active_player_o),
        .start_pulse_o  (start_pulse_o),
        .fire_pulse_o   (fire_pulse_o),
        .coin_locked_o  (coin_locked_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic coin_once();
        coin_i = 1'b1;
        tick(1);
        coin_i = 1'b0;
    endtask

    // Pulse monitor: every pulse must match the scoreboard head, and every expected one must appear
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (exp_fire_q.size() > 0 && exp_fire_q[0] == cyc) begin
                void'(exp_fire_q.pop_front());
                check("fire_pulse", int'(fire_pulse_o), 1);
            end else if (fire_pulse_o) begin
                check("fire_pulse_spurious", cyc, -1);
            end
            if (exp_start_q.size() > 0 && exp_start_q[0] == cyc) begin
                void'(exp_start_q.pop_front());
                check("start_pulse", int'(start_pulse_o), 1);
            end else if (start_pulse_o) begin
                check("start_pulse_spurious", cyc, -1);
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        {coin_i, p1_start_i, p2_start_i, fire_i, turn_end_i, game_over_i} = '0;
        tick(3);
        check("rst_credits", int'(credits_o), 0);
        check("rst_state", int'(state_o), 0);
        check("rst_locked", int'(coin_locked_o), 0);
        check("rst_pulses", int'({start_pulse_o, fire_pulse_o}), 0);
        rst_i = 1'b0;
        tick(2);

        // First coin, locked-out second coin, coin after lockout expires
        coin_once();
        c0 = cyc;
        check("coin1_credits", int'(credits_o), 1);
        check("coin1_state", int'(state_o), 1);
        check("coin1_locked", int'(coin_locked_o), 1);
        tick(8);
        coin_once();
        check("coin_locked_ignored", int'(credits_o), 1);
        tick(c0 + 62 - cyc);
        check("lock_last_cycle", int'(coin_locked_o), 1);
        tick(1);
        check("lock_released", int'(coin_locked_o), 0);
        coin_once();
        check("coin2_credits", int'(credits_o), 2);

        // Saturate at 9 with spaced coins
        for (int i = 0; i < 11; i++) begin
            tick(64);
            coin_once();
        end
        check("sat_credits", int'(credits_o), 9);
        check("sat_state", int'(state_o), 1);
        tick(64);

        // Coin and p1 start together at saturation
        exp_start_q.push_back(cyc + 1);
        coin_i = 1'b1;
        p1_start_i = 1'b1;
        tick(1);
        coin_i = 1'b0;
        p1_start_i = 1'b0;
        check("coinp1_credits", int'(credits_o), 8);
        check("coinp1_state", int'(state_o), 2);
        check("coinp1_two_player", int'(two_player_o), 0);
        check("coinp1_locked", int'(coin_locked_o), 1);

        // 1P game ignores turn_end
        turn_end_i = 1'b1;
        tick(1);
        turn_end_i = 1'b0;
        check("p1_turn_end_ignored", int'(active_player_o), 0);

        // Held fire for 50 cycles: four pulses 16 apart
        tick(2);
        exp_fire_q.push_back(cyc + 1);
        exp_fire_q.push_back(cyc + 17);
        exp_fire_q.push_back(cyc + 33);
        exp_fire_q.push_back(cyc + 49);
        fire_i = 1'b1;
        tick(50);
        fire_i = 1'b0;
        tick(20);
        check("burst_done", exp_fire_q.size(), 0);

        game_over_i = 1'b1;
        tick(1);
        game_over_i = 1'b0;
        check("go_1p_state", int'(state_o), 1);
        check("go_1p_credits", int'(credits_o), 8);

        // Fire outside PLAY produces nothing
        fire_i = 1'b1;
        tick(1);
        check("ready_fire", int'(fire_pulse_o), 0);
        tick(20);
        fire_i = 1'b0;
        tick(2);

        // Reset in the middle of a game
        exp_start_q.push_back(cyc + 1);
        p1_start_i = 1'b1;
        tick(1);
        p1_start_i = 1'b0;
        check("pre_rst_state", int'(state_o), 2);
        check("pre_rst_credits", int'(credits_o), 7);
        tick(3);
        rst_i = 1'b1;
        tick(1);
        check("midrst_credits", int'(credits_o), 0);
        check("midrst_state", int'(state_o), 0);
        check("midrst_pulses", int'({start_pulse_o, fire_pulse_o}), 0);
        rst_i = 1'b0;
        tick(2);

        // p2 start needs two credits
        coin_once();
        tick(1);
        p2_start_i = 1'b1;
        tick(1);
        p2_start_i = 1'b0;
        check("p2_c1_credits", int'(credits_o), 1);
        check("p2_c1_state", int'(state_o), 1);
        tick(64);
        coin_once();
        check("p2_coin_credits", int'(credits_o), 2);
        exp_start_q.push_back(cyc + 1);
        p2_start_i = 1'b1;
        tick(1);
        p2_start_i = 1'b0;
        check("p2_credits", int'(credits_o), 0);
        check("p2_state", int'(state_o), 2);
        check("p2_two_player", int'(two_player_o), 1);
        check("p2_active", int'(active_player_o), 0);
        turn_end_i = 1'b1;
        tick(1);
        turn_end_i = 1'b0;
        check("turn1_active", int'(active_player_o), 1);
        tick(1);
        turn_end_i = 1'b1;
        tick(1);
        turn_end_i = 1'b0;
        check("turn2_active", int'(active_player_o), 0);
        game_over_i = 1'b1;
        tick(1);
        game_over_i = 1'b0;
        check("go_2p_state", int'(state_o), 0);

        // 2P game left with two credits; game_over+turn_end lands on a due fire pulse
        for (int i = 0; i < 4; i++) begin
            tick(64);
            coin_once();
        end
        check("four_credits", int'(credits_o), 4);
        exp_start_q.push_back(cyc + 1);
        p2_start_i = 1'b1;
        tick(1);
        p2_start_i = 1'b0;
        check("t6_credits", int'(credits_o), 2);
        c0 = cyc;
        exp_fire_q.push_back(c0 + 1);
        exp_fire_q.push_back(c0 + 17);
        fire_i = 1'b1;
        tick(5);
        turn_end_i = 1'b1;
        tick(1);
        turn_end_i = 1'b0;
        check("t6_active_toggle", int'(active_player_o), 1);
        tick(c0 + 32 - cyc);
        turn_end_i = 1'b1;
        game_over_i = 1'b1;
        tick(1);
        turn_end_i = 1'b0;
        game_over_i = 1'b0;
        check("t6_state", int'(state_o), 1);
        check("t6_active", int'(active_player_o), 0);
        check("t6_fire_stopped", int'(fire_pulse_o), 0);
        check("t6_credits_kept", int'(credits_o), 2);
        tick(20);
        fire_i = 1'b0;
        tick(3);

        check("fire_queue_empty", exp_fire_q.size(), 0);
        check("start_queue_empty", exp_start_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
